// File: rtl/phy_lane_sched.sv
// Four-lane round-robin byte scheduler with an MSB-first serializer, 8 cycles per slot.
// After reset, SYNC_SLOTS COM slots precede lane data; IDLE fills slots with no requester.
//   state  | meaning
//   SYNC   | sending COM training slots after reset, lane requests ignored
//   ACTIVE | round-robin lane grant each slot, IDLE when no lane is valid
module phy_lane_sched #(
    parameter int unsigned SYNC_SLOTS = 4,
    parameter logic [7:0]  COM        = 8'hBC,
    parameter logic [7:0]  IDLE       = 8'h7C
) (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    output logic       ready0,
    output logic       ready1,
    output logic       ready2,
    output logic       ready3,
    output logic [7:0] sched_data,
    output logic [1:0] sched_lane,
    output logic       sched_valid,
    output logic       slot_start,
    output logic       ser_out
);
    localparam int unsigned SW = $clog2(SYNC_SLOTS + 1);

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    bit_cnt;
    logic [SW-1:0] sync_cnt;
    logic [1:0]    rr_ptr;
    logic [7:0]    shreg;
    logic [3:0]    ready_vec;

    logic          boundary;
    logic          last_sync;
    logic [3:0]    valid_vec;
    logic [7:0]    lane_byte [4];
    logic          grant_hit;
    logic [1:0]    grant_lane;
    logic [7:0]    sel_byte;
    logic          sel_valid;
    logic [1:0]    sel_lane;
    logic [3:0]    sel_ready;

    assign boundary     = (bit_cnt == 3'd0);
    assign last_sync    = (sync_cnt == SW'(SYNC_SLOTS - 1));
    assign valid_vec    = {valid_in3, valid_in2, valid_in1, valid_in0};
    assign lane_byte[0] = in0;
    assign lane_byte[1] = in1;
    assign lane_byte[2] = in2;
    assign lane_byte[3] = in3;

    always_ff @(posedge clk_32f) begin
        if (rst) state <= SYNC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == SYNC && boundary && last_sync) state_nxt = ACTIVE;
    end

    // Rotating-priority search starting at rr_ptr
    always_comb begin
        grant_hit  = 1'b0;
        grant_lane = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!grant_hit && valid_vec[rr_ptr + 2'(i)]) begin
                grant_hit  = 1'b1;
                grant_lane = rr_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        sel_byte  = IDLE;
        sel_valid = 1'b0;
        sel_lane  = 2'd0;
        sel_ready = 4'd0;
        if (state == SYNC) begin
            sel_byte = COM;
        end else if (grant_hit) begin
            sel_byte  = lane_byte[grant_lane];
            sel_valid = 1'b1;
            sel_lane  = grant_lane;
            sel_ready = 4'b0001 << grant_lane;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (rst) begin
            bit_cnt     <= 3'd0;
            sync_cnt    <= '0;
            rr_ptr      <= 2'd0;
            shreg       <= 8'd0;
            sched_data  <= 8'd0;
            sched_lane  <= 2'd0;
            sched_valid <= 1'b0;
            ready_vec   <= 4'd0;
            slot_start  <= 1'b0;
            ser_out     <= 1'b0;
        end else if (boundary) begin
            shreg       <= sel_byte;
            sched_data  <= sel_byte;
            sched_lane  <= sel_lane;
            sched_valid <= sel_valid;
            ready_vec   <= sel_ready;
            ser_out     <= sel_byte[7];
            slot_start  <= 1'b1;
            bit_cnt     <= 3'd1;
            if (state == SYNC) sync_cnt <= sync_cnt + SW'(1);
            if (state == ACTIVE && grant_hit) rr_ptr <= grant_lane + 2'd1;
        end else begin
            ser_out    <= shreg[3'd7 - bit_cnt];
            bit_cnt    <= bit_cnt + 3'd1;
            slot_start <= 1'b0;
            ready_vec  <= 4'd0;
        end
    end

    assign ready0 = ready_vec[0];
    assign ready1 = ready_vec[1];
    assign ready2 = ready_vec[2];
    assign ready3 = ready_vec[3];
endmodule
